operand_forward_unit: RTL and testbench
=======================================

Name: operand_forward_unit

Overview:
- Consumer end of the execution-pipe result interface.
- Operates at the register-fetch/issue boundary. Takes the per-stage packed results (stages 1-7) from the even and odd pipes plus both writeback ports. Resolves RAW hazards for the three source operands (ra, rb, rc) of the instruction being issued.
- Forwards the freshest ready value, or stalls issue when the producer has not reached its latency. Registers the selected operands into the operand-to-execute pipeline register.

Parameters:
- NUM_STAGES, 7, forwarding stages per pipe.
- DATA_W, 128, operand width.
- ADDR_W, 7, register address width.
- PKT_W, 143, packed result width: [0:2] unit_id, [3:130] result, [131:137] reg_dst, [138:141] latency, [142] reg_wr.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- issue_valid  in  1  instruction present at issue
- ra_addr, rb_addr, rc_addr  in  7 each  source register addresses
- ra_use, rb_use, rc_use  in  1 each  source actually read by the instruction
- ra_rf, rb_rf, rc_rf  in  128 each  register-file read data
- issue_info  in  32  opaque instruction side-band (instr_id, unit, dst, imm), carried to the execute stage
- even_pkts  in  7*143  even pipe stages 1..7; stage k occupies bits [(k-1)*143 : k*143-1]
- odd_pkts  in  7*143  odd pipe stages 1..7, same layout
- even_wb_addr, odd_wb_addr  in  7  writeback addresses
- even_wb_data, odd_wb_data  in  128  writeback data
- even_wb_en, odd_wb_en  in  1  writeback enables
- stall  out  1  combinational; issue must hold its instruction
- op_valid  out  1  registered operand bundle valid
- op_a, op_b, op_c  out  128 each  registered forwarded operands
- op_info  out  32  registered side-band
- stall_count  out  16  saturating count of stall cycles

Behaviour:
- Match: stage-k packet P matches source S when P.reg_wr=1 and P.reg_dst==S.addr.
- Search order per source: even s1, odd s1, even s2, odd s2, ... even s7, odd s7. The first match wins (youngest producer). If the same stage matches in both pipes, even wins (dual-issue to the same dst is illegal upstream; behaviour is still defined).
- Readiness: the winning match at stage k is ready iff P.latency <= k. Latency 0 counts as ready. If ready, forward P[3:130].
- Not ready: hazard for that source.
- No stage match: use the WB bypass. even_wb_en && even_wb_addr==addr selects even_wb_data. Otherwise odd_wb_en && odd_wb_addr==addr selects odd_wb_data. Otherwise use the *_rf data.
- Unused sources (x_use=0) never cause a hazard; their operand value is don't-care but must still follow the selection rules.
- stall = issue_valid && (any used source has a hazard). Purely combinational, same cycle.
- Register on posedge clk:
  - If issue_valid && !stall: op_valid<=1; op_a/b/c<=selected values; op_info<=issue_info.
  - Else: op_valid<=0 (bubble). op_a/b/c and op_info hold their previous values.
- stall_count increments on every cycle with stall=1 and saturates at 0xFFFF.
- Latency: forwarded data appears on op_* one clock after issue is accepted.
- Reset (asynchronous, any cycle, including mid-stall): op_valid=0, op_a/b/c=0, op_info=0, stall_count=0. stall is combinational and follows inputs; it is 0 when issue_valid=0.
- Post-reset first edge: normal operation. All-zero packets (reg_wr=0) never match.

Decomposition:
- Shared package: PKT_W, field offsets (UNIT, RES, DST, LAT, WR as lo/hi constants), NUM_STAGES, DATA_W, ADDR_W.
- Sub-module fwd_select: combinational search for one source. Inputs: addr, use, rf data, both packet buses, both WB ports. Outputs: data, hazard. Instantiated three times. The top holds the registers, stall logic and counter.

Test Plan:
- Reset then no matches: ra_addr=5, ra_rf=0x11.., issue_valid=1 -> next cycle op_valid=1, op_a=0x11.., stall=0, stall_count=0.
- Even s2 = {dst=5, lat=2, wr=1, result=0xAA..}, ra_addr=5 -> stall=0; next cycle op_a=0xAA...
- Even s1 = {dst=5, lat=4, wr=1}, ra_use=1 -> stall=1 and op_valid=0 next cycle. Advance the packet to s4 -> stall=0 and op_a is forwarded. stall_count=3.
- Priority: even s3 dst=7 result=0x33, odd s1 dst=7 lat=1 result=0x44 -> op_b=0x44. Same stage in both pipes -> even value selected.
- WB bypass: no stage match, even_wb_en=1 addr=9 data=0x99, rc_addr=9 -> op_c=0x99. Same with rc_use=0 and a non-ready stage match -> stall=0.
- Assert rst while stall=1 -> op_valid=0, stall_count=0 immediately. Then 70000 forced stall cycles -> stall_count=0xFFFF and holds.

Source files
------------

// File: rtl/operand_forward_unit_pkg.sv
// Shared constants and the packed execution-pipe result layout for the
// operand forwarding unit.
package operand_forward_unit_pkg;

  localparam int NUM_STAGES = 7;
  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 7;
  localparam int INFO_W     = 32;
  localparam int CNT_W      = 16;
  localparam int LAT_W      = 4;
  localparam int PKT_W      = 143;
  localparam int BUS_W      = NUM_STAGES * PKT_W;

  localparam int UNIT_LO = 0;
  localparam int UNIT_HI = 2;
  localparam int RES_LO  = 3;
  localparam int RES_HI  = 130;
  localparam int DST_LO  = 131;
  localparam int DST_HI  = 137;
  localparam int LAT_LO  = 138;
  localparam int LAT_HI  = 141;
  localparam int WR_LO   = 142;
  localparam int WR_HI   = 142;

  typedef struct packed {
    logic              reg_wr;
    logic [LAT_W-1:0]  latency;
    logic [ADDR_W-1:0] reg_dst;
    logic [DATA_W-1:0] result;
    logic [2:0]        unit_id;
  } result_pkt_t;

  function automatic result_pkt_t unpack_pkt(input logic [PKT_W-1:0] raw);
    result_pkt_t p;
    p.unit_id = raw[UNIT_HI:UNIT_LO];
    p.result  = raw[RES_HI:RES_LO];
    p.reg_dst = raw[DST_HI:DST_LO];
    p.latency = raw[LAT_HI:LAT_LO];
    p.reg_wr  = raw[WR_LO];
    return p;
  endfunction

endpackage

// File: rtl/operand_forward_unit_if.sv
// Issue-side, pipe-result and operand-bundle signals of the forwarding unit.
// Handshake: an instruction is accepted on a rising clk edge when
// issue_valid=1 and stall=0; while stall=1 the issuer holds every issue input.
interface operand_forward_unit_if;
  import operand_forward_unit_pkg::*;

  logic              issue_valid;
  logic [ADDR_W-1:0] ra_addr, rb_addr, rc_addr;
  logic              ra_use, rb_use, rc_use;
  logic [DATA_W-1:0] ra_rf, rb_rf, rc_rf;
  logic [INFO_W-1:0] issue_info;
  logic [BUS_W-1:0]  even_pkts, odd_pkts;
  logic [ADDR_W-1:0] even_wb_addr, odd_wb_addr;
  logic [DATA_W-1:0] even_wb_data, odd_wb_data;
  logic              even_wb_en, odd_wb_en;
  logic              stall;
  logic              op_valid;
  logic [DATA_W-1:0] op_a, op_b, op_c;
  logic [INFO_W-1:0] op_info;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output issue_valid, ra_addr, rb_addr, rc_addr, ra_use, rb_use, rc_use,
           ra_rf, rb_rf, rc_rf, issue_info, even_pkts, odd_pkts,
           even_wb_addr, odd_wb_addr, even_wb_data, odd_wb_data,
           even_wb_en, odd_wb_en,
    input  stall, op_valid, op_a, op_b, op_c, op_info, stall_count
  );

  modport slave (
    input  issue_valid, ra_addr, rb_addr, rc_addr, ra_use, rb_use, rc_use,
           ra_rf, rb_rf, rc_rf, issue_info, even_pkts, odd_pkts,
           even_wb_addr, odd_wb_addr, even_wb_data, odd_wb_data,
           even_wb_en, odd_wb_en,
    output stall, op_valid, op_a, op_b, op_c, op_info, stall_count
  );
endinterface

// File: rtl/operand_forward_unit_fwd_select.sv
// Combinational RAW resolution for one source operand: youngest matching
// producer across both pipes, then writeback bypass, then register file.
module operand_forward_unit_fwd_select
  import operand_forward_unit_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              src_use,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [BUS_W-1:0]  even_pkts,
  input  logic [BUS_W-1:0]  odd_pkts,
  input  logic [ADDR_W-1:0] even_wb_addr,
  input  logic [ADDR_W-1:0] odd_wb_addr,
  input  logic [DATA_W-1:0] even_wb_data,
  input  logic [DATA_W-1:0] odd_wb_data,
  input  logic              even_wb_en,
  input  logic              odd_wb_en,
  output logic [DATA_W-1:0] data,
  output logic              hazard
);

  result_pkt_t ev_pkt [NUM_STAGES];
  result_pkt_t od_pkt [NUM_STAGES];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_unpack
    assign ev_pkt[k] = unpack_pkt(even_pkts[k*PKT_W +: PKT_W]);
    assign od_pkt[k] = unpack_pkt(odd_pkts[k*PKT_W +: PKT_W]);
  end

  logic             found;
  result_pkt_t      hit;
  logic [LAT_W-1:0] hit_stage;
  logic             ready;

  // Scan youngest stage first; within a stage the even pipe is checked first.
  always_comb begin
    found     = 1'b0;
    hit       = '0;
    hit_stage = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (!found && ev_pkt[k].reg_wr && ev_pkt[k].reg_dst == addr) begin
        found     = 1'b1;
        hit       = ev_pkt[k];
        hit_stage = LAT_W'(k + 1);
      end else if (!found && od_pkt[k].reg_wr && od_pkt[k].reg_dst == addr) begin
        found     = 1'b1;
        hit       = od_pkt[k];
        hit_stage = LAT_W'(k + 1);
      end
    end
  end

  assign ready  = (hit.latency <= hit_stage);
  assign hazard = src_use && found && !ready;

  always_comb begin
    data = rf_data;
    if (found)
      data = hit.result;
    else if (even_wb_en && even_wb_addr == addr)
      data = even_wb_data;
    else if (odd_wb_en && odd_wb_addr == addr)
      data = odd_wb_data;
  end

endmodule

// File: rtl/operand_forward_unit.sv
// Issue-stage operand forwarding: resolves ra/rb/rc, raises stall on an
// unready producer and registers the operand bundle toward execute.
module operand_forward_unit
  import operand_forward_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  operand_forward_unit_if.slave bus
);

  logic [DATA_W-1:0] sel_a, sel_b, sel_c;
  logic              hz_a, hz_b, hz_c;
  logic              stall_i;
  logic              accept;

  operand_forward_unit_fwd_select u_sel_a (
    .addr(bus.ra_addr), .src_use(bus.ra_use), .rf_data(bus.ra_rf),
    .even_pkts(bus.even_pkts), .odd_pkts(bus.odd_pkts),
    .even_wb_addr(bus.even_wb_addr), .odd_wb_addr(bus.odd_wb_addr),
    .even_wb_data(bus.even_wb_data), .odd_wb_data(bus.odd_wb_data),
    .even_wb_en(bus.even_wb_en), .odd_wb_en(bus.odd_wb_en),
    .data(sel_a), .hazard(hz_a)
  );

  operand_forward_unit_fwd_select u_sel_b (
    .addr(bus.rb_addr), .src_use(bus.rb_use), .rf_data(bus.rb_rf),
    .even_pkts(bus.even_pkts), .odd_pkts(bus.odd_pkts),
    .even_wb_addr(bus.even_wb_addr), .odd_wb_addr(bus.odd_wb_addr),
    .even_wb_data(bus.even_wb_data), .odd_wb_data(bus.odd_wb_data),
    .even_wb_en(bus.even_wb_en), .odd_wb_en(bus.odd_wb_en),
    .data(sel_b), .hazard(hz_b)
  );

  operand_forward_unit_fwd_select u_sel_c (
    .addr(bus.rc_addr), .src_use(bus.rc_use), .rf_data(bus.rc_rf),
    .even_pkts(bus.even_pkts), .odd_pkts(bus.odd_pkts),
    .even_wb_addr(bus.even_wb_addr), .odd_wb_addr(bus.odd_wb_addr),
    .even_wb_data(bus.even_wb_data), .odd_wb_data(bus.odd_wb_data),
    .even_wb_en(bus.even_wb_en), .odd_wb_en(bus.odd_wb_en),
    .data(sel_c), .hazard(hz_c)
  );

  assign stall_i   = bus.issue_valid && (hz_a || hz_b || hz_c);
  assign accept    = bus.issue_valid && !stall_i;
  assign bus.stall = stall_i;

  logic              op_valid_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, op_c_q;
  logic [INFO_W-1:0] op_info_q;
  logic [CNT_W-1:0]  stall_count_q;

  // Operands hold across bubbles so execute sees stable data when op_valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_q    <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_c_q        <= '0;
      op_info_q     <= '0;
      stall_count_q <= '0;
    end else begin
      op_valid_q <= accept;
      if (accept) begin
        op_a_q    <= sel_a;
        op_b_q    <= sel_b;
        op_c_q    <= sel_c;
        op_info_q <= bus.issue_info;
      end
      if (stall_i && stall_count_q != '1)
        stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign bus.op_valid    = op_valid_q;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.op_c        = op_c_q;
  assign bus.op_info     = op_info_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed and randomized checks of operand_forward_unit against a
// priority-list reference model.
module tb_operand_forward_unit;

  typedef struct {
    bit         wr;
    bit [3:0]   lat;
    bit [6:0]   dst;
    bit [127:0] res;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_forward_unit_if bus ();
  operand_forward_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // stimulus state
  logic         iv;
  logic [6:0]   addr [3];
  logic         use_ [3];
  logic [127:0] rf   [3];
  logic [31:0]  info;
  pkt_t         ev [7];
  pkt_t         od [7];
  logic [6:0]   ewa, owa;
  logic [127:0] ewd, owd;
  logic         ewe, owe;

  // expected registered state
  logic         exp_valid;
  logic [127:0] exp_op [3];
  logic         exp_care [3];
  logic [31:0]  exp_info;
  logic [15:0]  exp_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [142:0] pack(input pkt_t p);
    return {p.wr, p.lat, p.dst, p.res, 3'b000};
  endfunction

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic pkt_t mk(input bit [6:0] dst, input bit [3:0] lat, input bit [127:0] res);
    pkt_t p;
    p.wr = 1'b1; p.dst = dst; p.lat = lat; p.res = res;
    return p;
  endfunction

  task automatic clear();
    iv = 1'b0; info = '0; ewa = '0; owa = '0; ewd = '0; owd = '0; ewe = 1'b0; owe = 1'b0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; use_[i] = 1'b1; rf[i] = '0; end
    for (int k = 0; k < 7; k++) begin ev[k] = '{0, 0, 0, 0}; od[k] = '{0, 0, 0, 0}; end
  endtask

  task automatic apply();
    bus.issue_valid = iv;
    bus.ra_addr = addr[0]; bus.rb_addr = addr[1]; bus.rc_addr = addr[2];
    bus.ra_use = use_[0];  bus.rb_use = use_[1];  bus.rc_use = use_[2];
    bus.ra_rf = rf[0];     bus.rb_rf = rf[1];     bus.rc_rf = rf[2];
    bus.issue_info = info;
    for (int k = 0; k < 7; k++) begin
      bus.even_pkts[k*143 +: 143] = pack(ev[k]);
      bus.odd_pkts[k*143 +: 143]  = pack(od[k]);
    end
    bus.even_wb_addr = ewa; bus.odd_wb_addr = owa;
    bus.even_wb_data = ewd; bus.odd_wb_data = owd;
    bus.even_wb_en = ewe;   bus.odd_wb_en = owe;
  endtask

  // Reference: walk producers in priority order; first hit decides.
  function automatic void ref_sel(input logic [6:0] a, input logic u, input logic [127:0] rfd,
                                  output logic [127:0] d, output logic hz, output logic care);
    pkt_t cand [$];
    for (int k = 0; k < 7; k++) begin cand.push_back(ev[k]); cand.push_back(od[k]); end
    hz = 1'b0; care = 1'b1;
    for (int i = 0; i < cand.size(); i++) begin
      if (cand[i].wr && cand[i].dst == a) begin
        d = cand[i].res;
        if (int'(cand[i].lat) > i / 2 + 1) begin hz = u; care = 1'b0; end
        return;
      end
    end
    if (ewe && ewa == a)      d = ewd;
    else if (owe && owa == a) d = owd;
    else                      d = rfd;
  endfunction

  task automatic step();
    logic [127:0] d [3];
    logic         hz [3];
    logic         cr [3];
    logic         st;
    apply();
    #1;
    for (int i = 0; i < 3; i++) ref_sel(addr[i], use_[i], rf[i], d[i], hz[i], cr[i]);
    st = iv && (hz[0] || hz[1] || hz[2]);
    chk("stall", {127'b0, bus.stall}, {127'b0, st});
    @(posedge clk);
    if (st && exp_cnt != 16'hFFFF) exp_cnt++;
    exp_valid = iv && !st;
    if (exp_valid) begin
      for (int i = 0; i < 3; i++) begin exp_op[i] = d[i]; exp_care[i] = cr[i]; end
      exp_info = info;
    end
    @(negedge clk);
    chk("op_valid", {127'b0, bus.op_valid}, {127'b0, exp_valid});
    if (exp_care[0]) chk("op_a", bus.op_a, exp_op[0]);
    if (exp_care[1]) chk("op_b", bus.op_b, exp_op[1]);
    if (exp_care[2]) chk("op_c", bus.op_c, exp_op[2]);
    chk("op_info", {96'b0, bus.op_info}, {96'b0, exp_info});
    chk("stall_count", {112'b0, bus.stall_count}, {112'b0, exp_cnt});
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_info = '0; exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin exp_op[i] = '0; exp_care[i] = 1'b1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {127'b0, bus.op_valid}, 128'd0);
    chk({tag, "_a"}, bus.op_a, 128'd0);
    chk({tag, "_b"}, bus.op_b, 128'd0);
    chk({tag, "_c"}, bus.op_c, 128'd0);
    chk({tag, "_info"}, {96'b0, bus.op_info}, 128'd0);
    chk({tag, "_cnt"}, {112'b0, bus.stall_count}, 128'd0);
  endtask

  initial begin
    clear();
    apply();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_stall_idle", {127'b0, bus.stall}, 128'd0);
    rst = 1'b0;

    // no matches: register file data
    iv = 1'b1; addr[0] = 7'd5; rf[0] = rep(8'h11); info = 32'hCAFE_0001;
    step();
    chk("rf_path_a", bus.op_a, rep(8'h11));

    // ready producer in even stage 2
    ev[1] = mk(7'd5, 4'd2, rep(8'hAA)); info = 32'hCAFE_0002;
    step();
    chk("even_s2_fwd", bus.op_a, rep(8'hAA));

    // latency-4 producer walks s1 -> s4
    clear(); iv = 1'b1; addr[0] = 7'd5; rf[0] = rep(8'h11); info = 32'hCAFE_0003;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 7; j++) ev[j] = '{0, 0, 0, 0};
      ev[k] = mk(7'd5, 4'd4, rep(8'hBE));
      step();
    end
    chk("stall_cnt_3", {112'b0, bus.stall_count}, 128'd3);
    chk("lat4_fwd", bus.op_a, rep(8'hBE));

    // younger odd producer beats older even one; same stage -> even
    clear(); iv = 1'b1; addr[1] = 7'd7; info = 32'hCAFE_0004;
    ev[2] = mk(7'd7, 4'd0, rep(8'h33));
    od[0] = mk(7'd7, 4'd1, rep(8'h44));
    step();
    chk("prio_odd_s1", bus.op_b, rep(8'h44));
    ev[0] = mk(7'd7, 4'd0, rep(8'h55));
    step();
    chk("prio_even_same_stage", bus.op_b, rep(8'h55));

    // writeback bypass, even over odd, then odd alone
    clear(); iv = 1'b1; addr[2] = 7'd9; rf[2] = rep(8'h01); info = 32'hCAFE_0005;
    ewe = 1'b1; ewa = 7'd9; ewd = rep(8'h99);
    owe = 1'b1; owa = 7'd9; owd = rep(8'h77);
    step();
    chk("wb_even", bus.op_c, rep(8'h99));
    ewe = 1'b0;
    step();
    chk("wb_odd", bus.op_c, rep(8'h77));

    // unused source with unready producer does not stall
    use_[2] = 1'b0; ev[0] = mk(7'd9, 4'd5, rep(8'h66));
    step();
    chk("unused_no_stall_valid", {127'b0, bus.op_valid}, 128'd1);

    // idle issue never stalls
    iv = 1'b0; use_[2] = 1'b1;
    step();

    // randomized traffic over a small register window
    for (int n = 0; n < 400; n++) begin
      clear();
      iv = ($urandom_range(0, 7) != 0);
      info = $urandom();
      for (int i = 0; i < 3; i++) begin
        addr[i] = 7'($urandom_range(0, 7));
        use_[i] = ($urandom_range(0, 4) != 0);
        rf[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      for (int k = 0; k < 7; k++) begin
        if ($urandom_range(0, 2) == 0)
          ev[k] = mk(7'($urandom_range(0, 7)), 4'($urandom_range(0, 9)), {4{$urandom()}});
        if ($urandom_range(0, 2) == 0)
          od[k] = mk(7'($urandom_range(0, 7)), 4'($urandom_range(0, 9)), {4{$urandom()}});
        if ($urandom_range(0, 5) == 0) ev[k].wr = 1'b0;
      end
      ewe = $urandom_range(0, 1) == 1; ewa = 7'($urandom_range(0, 7)); ewd = {4{$urandom()}};
      owe = $urandom_range(0, 1) == 1; owa = 7'($urandom_range(0, 7)); owd = {4{$urandom()}};
      step();
    end

    // accepted issue, then a stall, then asynchronous reset mid-stall
    clear(); iv = 1'b1; addr[0] = 7'd3; rf[0] = rep(8'h5A); info = 32'hCAFE_0006;
    step();
    ev[0] = mk(7'd3, 4'd7, rep(8'hEE));
    step();
    apply();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    chk("rst_stall_follows", {127'b0, bus.stall}, 128'd1);
    @(negedge clk);
    rst = 1'b0;

    // long forced stall saturates the counter
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", {112'b0, bus.stall_count}, 128'hFFFF);
    chk("sat_valid", {127'b0, bus.op_valid}, 128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", {112'b0, bus.stall_count}, 128'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
